mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle control unit for the MIPS-subset CPU.
- Drives the enable inputs of the enable/clear flip-flop registers (PC, IR, register file, data memory) and the datapath mux selects, one instruction phase per clock.
- Sits directly upstream of those registers: its WPC/WIR outputs are their En lines.
- Decodes Op/Func from the IR register and Zero from the ALU.

Parameters:
- ST_W, 3, width of the State output and internal state register.
- ALU_ADD, 3'b010, ALUC code for add.
- ALU_SUB, 3'b110, ALUC code for subtract.

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  synchronous active-high reset.
- Op  input  6  instruction[31:26] from IR.
- Func  input  6  instruction[5:0] from IR.
- Zero  input  1  ALU zero flag, current cycle.
- WPC  output  1  PC register enable.
- WIR  output  1  IR register enable.
- WMEM  output  1  data memory write enable.
- WREG  output  1  register file write enable.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- RegDst  output  1  write register: 0=rt, 1=rd.
- MemtoReg  output  1  write data: 0=ALUOut, 1=MDR.
- ALUSrcA  output  1  0=PC, 1=rs data.
- ALUSrcB  output  2  00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUC  output  3  ALU operation.
- PCSource  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump address.
- Illegal  output  1  one-cycle pulse in ID on an unsupported opcode or function code.
- Done  output  1  one-cycle pulse in the last cycle of each legal instruction.
- State  output  3  current state, for debug.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high (Clr). When Clr=1 at a rising edge, the next state is IF, regardless of current state or inputs (including mid-instruction).
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5-7 are unreachable; if entered, the next state is IF with all write enables 0.
- Outputs: combinational from State, Op, Func and Zero (Moore except the beq WPC term). Defaults are all 0, ALUC=ALU_ADD.
- Reset value of every output: the IF-state values below.
  - WPC=1, WIR=1, ALUSrcB=01, ALUC=010, State=0.
  - All other outputs 0.
- Supported opcodes:
  - R-type 000000, with Func add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- IF: WPC=1, WIR=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUC=add. Next state is ID.
- ID: ALUSrcA=0, ALUSrcB=11, ALUC=add (branch target into ALUOut).
  - j: WPC=1, PCSource=10, Done=1; next state IF.
  - Illegal opcode or R-type Func: Illegal=1, no write enables asserted; next state IF.
  - Otherwise next state EXE.
- EXE:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUC per Func (add 010, sub 110, and 000, or 001, slt 111); next state WB.
  - lw/sw/addi: ALUSrcA=1, ALUSrcB=10, ALUC=add. lw/sw go to MEM; addi goes to WB.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUC=sub, PCSource=01, WPC=Zero, Done=1; next state IF.
- MEM: IorD=1.
  - lw: next state WB.
  - sw: WMEM=1, Done=1; next state IF.
- WB: WREG=1, Done=1; next state IF.
  - R-type: RegDst=1, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
  - addi: RegDst=0, MemtoReg=0.
- Cycle counts per instruction: j 2; beq 3; R-type/addi/sw 4; lw 5.
- Exclusivity: WMEM and WREG are never both 1. In IF, WPC and WIR are asserted together for exactly one cycle.
- Stable decode: Op/Func are assumed stable from ID onward, because IR is written only in IF. The block holds no copy of them.

Test Plan:
- Clr=1 for 2 cycles from an arbitrary state, then Clr=0 -> State=0 with WPC=1, WIR=1, ALUSrcB=01, ALUC=010; the next edge gives State=1.
- Op=000000, Func=100010 (sub) -> states 0,1,2,4,0. ALUC=110 in EXE; WREG=1 and RegDst=1 in WB; Done pulses once.
- Op=100011 (lw) -> states 0,1,2,3,4. IorD=1 in MEM; MemtoReg=1, RegDst=0, WREG=1 in WB.
- Op=101011 (sw) -> WMEM=1 only in state 3, then State=0.
- Op=000100 (beq): Zero=1 in EXE gives WPC=1, PCSource=01. Rerun with Zero=0 -> WPC=0; both runs return to IF after 3 cycles.
- Op=000010 (j) -> WPC=1, PCSource=10 in ID; State returns to 0 after 2 cycles.
- Op=111111 -> Illegal=1 in ID with no write enables, then IF. Separately, assert Clr during MEM of a lw -> next State=0 and WREG is never asserted.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB and drives
// register enables and datapath mux selects from the current state and decoded instruction.
module mc_control_fsm #(
  parameter int unsigned ST_W    = 3,
  parameter logic [2:0]  ALU_ADD = 3'b010,
  parameter logic [2:0]  ALU_SUB = 3'b110
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic [5:0]      Op,
  input  logic [5:0]      Func,
  input  logic            Zero,
  output logic            WPC,
  output logic            WIR,
  output logic            WMEM,
  output logic            WREG,
  output logic            IorD,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUC,
  output logic [1:0]      PCSource,
  output logic            Illegal,
  output logic            Done,
  output logic [ST_W-1:0] State
);

  typedef enum logic [ST_W-1:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StExe = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e state_q, state_d;

  logic       is_rtype;
  logic       func_ok;
  logic       op_ok;
  logic [2:0] rtype_aluc;

  // R-type function decode: legality and ALU operation.
  always_comb begin
    func_ok    = 1'b1;
    rtype_aluc = ALU_ADD;
    case (Func)
      6'b100000: rtype_aluc = ALU_ADD;
      6'b100010: rtype_aluc = ALU_SUB;
      6'b100100: rtype_aluc = 3'b000;
      6'b100101: rtype_aluc = 3'b001;
      6'b101010: rtype_aluc = 3'b111;
      default:   func_ok    = 1'b0;
    endcase
  end

  assign is_rtype = (Op == OpRtype);

  always_comb begin
    case (Op)
      OpRtype: op_ok = func_ok;
      OpLw, OpSw, OpBeq, OpJ, OpAddi: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    WPC      = 1'b0;
    WIR      = 1'b0;
    WMEM     = 1'b0;
    WREG     = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUC     = ALU_ADD;
    PCSource = 2'b00;
    Illegal  = 1'b0;
    Done     = 1'b0;
    state_d  = StIf;

    case (state_q)
      StIf: begin
        WPC     = 1'b1;
        WIR     = 1'b1;
        ALUSrcB = 2'b01;
        state_d = StId;
      end
      StId: begin
        // Branch target is computed here speculatively for beq.
        ALUSrcB = 2'b11;
        if (!op_ok) begin
          Illegal = 1'b1;
        end else if (Op == OpJ) begin
          WPC      = 1'b1;
          PCSource = 2'b10;
          Done     = 1'b1;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        ALUSrcA = 1'b1;
        if (is_rtype) begin
          ALUC    = rtype_aluc;
          state_d = StWb;
        end else begin
          case (Op)
            OpLw, OpSw: begin
              ALUSrcB = 2'b10;
              state_d = StMem;
            end
            OpAddi: begin
              ALUSrcB = 2'b10;
              state_d = StWb;
            end
            OpBeq: begin
              ALUC     = ALU_SUB;
              PCSource = 2'b01;
              WPC      = Zero;
              Done     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMem: begin
        IorD = 1'b1;
        if (Op == OpSw) begin
          WMEM = 1'b1;
          Done = 1'b1;
        end else if (Op == OpLw) begin
          state_d = StWb;
        end
      end
      StWb: begin
        WREG     = 1'b1;
        Done     = 1'b1;
        RegDst   = is_rtype;
        MemtoReg = (Op == OpLw);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;

endmodule
